// File: rtl/risc5_mem_pkg.sv
// risc5_mem_pkg: shared encodings and widths for the memory-side arbiters
package risc5_mem_pkg;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_VID = 1'b1;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_VID = 2'd2
    } state_t;
endpackage

// File: rtl/dport_pick.sv
// dport_pick: combinational winner selection; pri decides a tie
module dport_pick
    import risc5_mem_pkg::*;
(
    input  logic cpu_stb,
    input  logic vid_stb,
    input  logic pri,
    output logic win
);
    assign win = (cpu_stb && vid_stb) ? pri : (vid_stb ? REQ_VID : REQ_CPU);
endmodule

// File: rtl/dport_arb.sv
// dport_arb: shares the ramctrl data port between CPU and video, one transaction in flight
// DPORT_ARB_RR_EN selects round-robin tie-break; otherwise HI_PRIO wins ties
module dport_arb
    import risc5_mem_pkg::*;
#(
    parameter bit HI_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          vid_stb,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_ack,
    output logic          mem_stb,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ack
);
    state_t state;
    logic   win, pri;

`ifdef DPORT_ARB_RR_EN
    logic last;
    assign pri = ~last;
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= REQ_VID;
        else if (state == IDLE && (cpu_stb || vid_stb)) last <= win;
`else
    assign pri = HI_PRIO;
`endif

    dport_pick u_pick (.cpu_stb(cpu_stb), .vid_stb(vid_stb), .pri(pri), .win(win));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_stb  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (state == IDLE) begin
            if (cpu_stb || vid_stb) begin
                state    <= win ? BUSY_VID : BUSY_CPU;
                mem_stb  <= 1'b1;
                mem_we   <= ~win & cpu_we;
                mem_addr <= win ? vid_addr : cpu_addr;
                mem_din  <= win ? '0 : cpu_din;
            end
        end else if (mem_ack) begin
            state   <= IDLE;
            mem_stb <= 1'b0;
        end
    end

    // acks are combinational so completion adds no latency over ramctrl
    assign cpu_ack  = mem_ack && state == BUSY_CPU;
    assign vid_ack  = mem_ack && state == BUSY_VID;
    assign cpu_dout = mem_dout;
    assign vid_dout = mem_dout;
endmodule

// File: tb/tb_dport_arb.sv
// tb_dport_arb: directed test-plan scenarios then randomized traffic against a transaction model
module tb_dport_arb;
`ifdef DPORT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam bit HP = 1'b1;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_stb = 0, cpu_we = 0, vid_stb = 0, mem_ack = 0;
    logic [21:0] cpu_addr = 0, vid_addr = 0, mem_addr;
    logic [31:0] cpu_din = 0, mem_dout = 0, cpu_dout, vid_dout, mem_din;
    logic        cpu_ack, vid_ack, mem_stb, mem_we;
    int          nvec = 0, nerr = 0;

    dport_arb #(.HI_PRIO(HP)) dut (
        .clk(clk), .rst(rst),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_stb(vid_stb), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .mem_stb(mem_stb), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input bit c, input bit v, input int lastg);
        if (c && v) return RR ? (lastg == 1 ? 0 : 1) : int'(HP);
        return v ? 1 : 0;
    endfunction

    int          owner, lat, lastg;
    bit          ca_prev, va_prev, ew, ev;
    logic [21:0] ea;
    logic [31:0] ed;

    initial begin
        cyc(); cyc();
        check("rst_stb", mem_stb, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);
        check("rst_cack", cpu_ack, 0);
        check("rst_vack", vid_ack, 0);
        rst = 0;
        cyc();
        check("idle_stb", mem_stb, 0);

        cpu_stb = 1; cpu_we = 1; cpu_addr = 22'h0A1B2C; cpu_din = 32'hDEADBEEF;
        cyc();
        check("cw_stb", mem_stb, 1);
        check("cw_addr", mem_addr, 22'h0A1B2C);
        check("cw_din", mem_din, 32'hDEADBEEF);
        check("cw_we", mem_we, 1);
        cpu_addr = 22'h000123;
        cyc();
        check("cw_hold", mem_addr, 22'h0A1B2C);
        check("cw_noack", cpu_ack, 0);
        mem_ack = 1; #1;
        check("cw_ack", cpu_ack, 1);
        check("cw_vack", vid_ack, 0);
        cyc();
        mem_ack = 0; cpu_stb = 0; cpu_we = 0;
        check("cw_done", mem_stb, 0);

        vid_stb = 1; vid_addr = 22'h3F0000;
        cyc();
        check("vr_stb", mem_stb, 1);
        check("vr_we", mem_we, 0);
        check("vr_addr", mem_addr, 22'h3F0000);
        check("vr_din", mem_din, 0);
        mem_ack = 1; mem_dout = 32'h12345678; #1;
        check("vr_ack", vid_ack, 1);
        check("vr_cack", cpu_ack, 0);
        check("vr_dout", vid_dout, 32'h12345678);
        cyc();
        mem_ack = 0; vid_stb = 0;

        // last grant was video, so a round-robin tie starts with the CPU
        cpu_stb = 1; vid_stb = 1; cpu_addr = 22'h111111; vid_addr = 22'h222222;
        for (int i = 0; i < 4; i++) begin
            ev = RR ? bit'(i % 2) : (i < 3);
            cyc();
            check("tie_stb", mem_stb, 1);
            check("tie_addr", mem_addr, ev ? 22'h222222 : 22'h111111);
            mem_ack = 1; #1;
            check("tie_cack", cpu_ack, !ev);
            check("tie_vack", vid_ack, ev);
            cyc();
            mem_ack = 0;
            check("tie_gap", mem_stb, 0);
            if (!RR && i == 2) vid_stb = 0;
        end
        cpu_stb = 0; vid_stb = 0;
        cyc();

        mem_ack = 1; #1;
        check("sp_cack", cpu_ack, 0);
        check("sp_vack", vid_ack, 0);
        cyc();
        mem_ack = 0;
        check("sp_idle", mem_stb, 0);
        cpu_stb = 1; cpu_we = 0; cpu_addr = 22'h055AA5;
        cyc();
        check("sp_rd_stb", mem_stb, 1);
        check("sp_rd_we", mem_we, 0);
        mem_ack = 1; mem_dout = 32'hCAFEF00D; #1;
        check("sp_rd_ack", cpu_ack, 1);
        check("sp_rd_dout", cpu_dout, 32'hCAFEF00D);
        cyc();
        mem_ack = 0; cpu_stb = 0;

        cpu_stb = 1; cpu_addr = 22'h1ABCDE;
        cyc();
        check("rm_stb", mem_stb, 1);
        #2 rst = 1; #1;
        check("rm_clr", mem_stb, 0);
        check("rm_noack", cpu_ack, 0);
        cyc();
        rst = 0;
        cyc();
        check("rm_regrant", mem_stb, 1);
        check("rm_addr", mem_addr, 22'h1ABCDE);
        mem_ack = 1; #1;
        check("rm_ack", cpu_ack, 1);
        cyc();
        mem_ack = 0; cpu_stb = 0;
        cyc();

        owner = -1; lat = 0; lastg = 0; ca_prev = 0; va_prev = 0;
        ea = 0; ed = 0; ew = 0;
        for (int n = 0; n < 800; n++) begin
            check("r_stb", mem_stb, owner >= 0);
            if (owner >= 0) begin
                check("r_addr", mem_addr, ea);
                check("r_we", mem_we, ew);
                check("r_din", mem_din, ed);
            end
            if (!cpu_stb || ca_prev) begin
                cpu_stb = $urandom_range(0, 2) == 0;
                cpu_we = $urandom_range(0, 1);
                cpu_addr = 22'($urandom);
                cpu_din = $urandom;
            end else if (owner == 0 && $urandom_range(0, 1)) begin
                cpu_addr = 22'($urandom);
                cpu_din = $urandom;
                cpu_we = $urandom_range(0, 1);
            end
            if (!vid_stb || va_prev) begin
                vid_stb = $urandom_range(0, 2) == 0;
                vid_addr = 22'($urandom);
            end else if (owner == 1 && $urandom_range(0, 1)) begin
                vid_addr = 22'($urandom);
            end
            mem_ack = owner >= 0 ? (lat == 0) : ($urandom_range(0, 7) == 0);
            mem_dout = $urandom;
            #1;
            check("r_cack", cpu_ack, mem_ack && owner == 0);
            check("r_vack", vid_ack, mem_ack && owner == 1);
            check("r_cdout", cpu_dout, mem_dout);
            check("r_vdout", vid_dout, mem_dout);
            ca_prev = mem_ack && owner == 0;
            va_prev = mem_ack && owner == 1;
            if (owner >= 0) begin
                if (mem_ack) owner = -1;
                else lat--;
            end else if (cpu_stb || vid_stb) begin
                owner = pick(cpu_stb, vid_stb, lastg);
                lastg = owner;
                ea = owner == 1 ? vid_addr : cpu_addr;
                ew = owner == 0 && cpu_we;
                ed = owner == 1 ? 32'h0 : cpu_din;
                lat = $urandom_range(0, 3);
            end
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dport_arb.md
# dport_arb

Two-requester arbiter in front of the RAM controller's data port: shares the single `data_*` channel between the CPU load/store unit (read/write) and the video refresh fetcher (read-only). Sits between the CPU/video logic and `ramctrl`; the instruction port of `ramctrl` is untouched. One transaction in flight at a time, registered request path, pass-through response path.

## Interface
- `HI_PRIO`, default 1: requester that wins a tie when round-robin is compiled out (0 = CPU, 1 = video).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_stb` in 1: CPU request, held high until `cpu_ack`.
- `cpu_we` in 1: CPU write enable, valid with `cpu_stb`.
- `cpu_addr` in 22 (`[23:2]`): CPU word address.
- `cpu_din` in 32: CPU write data.
- `cpu_dout` out 32: read data to CPU.
- `cpu_ack` out 1: one-cycle completion pulse to CPU.
- `vid_stb` in 1: video read request, held high until `vid_ack`.
- `vid_addr` in 22 (`[23:2]`): video word address.
- `vid_dout` out 32: read data to video.
- `vid_ack` out 1: one-cycle completion pulse to video.
- `mem_stb` out 1: request to `ramctrl` data port.
- `mem_we` out 1: write enable to `ramctrl`.
- `mem_addr` out 22 (`[23:2]`): address to `ramctrl`.
- `mem_din` out 32: write data to `ramctrl`.
- `mem_dout` in 32: read data from `ramctrl`.
- `mem_ack` in 1: one-cycle completion pulse from `ramctrl`.

## Operation
- States: IDLE, BUSY_CPU, BUSY_VID.
- IDLE: if any `*_stb` is high, pick a winner, register `mem_addr`/`mem_we`/`mem_din` from the winner, set `mem_stb`=1, go to BUSY_x. Video grant forces `mem_we`=0 and `mem_din`=0.
- BUSY_x: hold `mem_*` stable and `mem_stb`=1 until `mem_ack`. On `mem_ack`: pulse `x_ack` in the same cycle (combinational from `mem_ack` gated by state), clear `mem_stb`, return to IDLE.
- `cpu_dout` and `vid_dout` both wire directly to `mem_dout`. Valid only in the requester's ack cycle.
- Non-granted requester sees no ack and keeps its `stb` high. Its request is sampled again in the next IDLE.
- Requesters drop `stb` in the cycle after their ack, or keep it high to issue a new request. A still-high `stb` in IDLE is treated as a new request.
- `mem_ack` in IDLE is spurious. It is ignored: no requester ack, no state change.
- Changes to `*_addr`/`*_din` while in BUSY are ignored, because the request path is registered at grant.

## Timing
- Reset values: state IDLE, `mem_stb`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `cpu_ack`=0, `vid_ack`=0. The `*_dout` outputs follow `mem_dout`.
- Arbitration latency: `stb` high in IDLE at cycle N, `mem_stb` high at cycle N+1.
- Completion: `x_ack` is asserted in the same cycle as `mem_ack`, with zero added latency.
- Turnaround: at least one IDLE cycle between transactions. Back-to-back throughput is one transaction per (ramctrl latency + 1) cycles.
- Reset asserted mid-transaction: immediate return to IDLE with `mem_stb`=0. The transaction is abandoned with no ack. `ramctrl` shares `rst`.

## Configuration
- `DPORT_ARB_RR_EN` defined: round-robin. A `last` flop records the most recent grant, and a tie goes to the other requester. `last` resets to 1, so the first tie goes to the CPU.
- Not defined: fixed priority. A tie always goes to `HI_PRIO`, and the `last` flop is not built.

## Structure
- Shared package/header `risc5_mem_pkg`: state encodings (IDLE=0, BUSY_CPU=1, BUSY_VID=2), address width 22, data width 32, requester IDs (CPU=0, VID=1).
- One sub-module, `dport_pick`: combinational winner selection from `cpu_stb`, `vid_stb`, `last`/`HI_PRIO`.
- The state machine and request registers stay in `dport_arb`.

## Test plan
- **Single CPU write:** `cpu_stb`=1, `cpu_we`=1, `cpu_addr`=22'h0A1B2C, `cpu_din`=32'hDEADBEEF.
  - Required: `mem_stb`=1 next cycle with matching addr/data and `mem_we`=1.
  - Required: `cpu_ack` coincides with `mem_ack`.
  - Required: `vid_ack` stays 0.
- **Single video read:** `vid_stb`=1, `vid_addr`=22'h3F0000.
  - Required: `mem_we`=0.
  - Required: `vid_dout`=`mem_dout`=32'h12345678 in the `vid_ack` cycle.
- **Simultaneous requests, round-robin build:** both `stb` held high for 4 transactions.
  - Required: grants alternate CPU, VID, CPU, VID.
  - Required: each ack goes only to its owner.
- **Simultaneous requests, fixed build:** `HI_PRIO`=1, both `stb` held high for 3 transactions.
  - Required: all 3 granted to video.
  - Required: CPU is granted once `vid_stb` drops.
- **Spurious ack:** `mem_ack` pulsed in IDLE.
  - Required: no `cpu_ack`/`vid_ack`, state stays IDLE.
  - Then a CPU read completes normally.
- **Reset mid-transaction:** `rst` raised in BUSY_CPU before `mem_ack`.
  - Required: `mem_stb`=0 immediately, no `cpu_ack`.
  - Required: after release, a pending `cpu_stb` is re-granted from IDLE.
